// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding and default sizing for the APB arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/apb_arb_rr2.sv
// rtl/apb_arb_rr2.sv - two-way round-robin grant, one-hot output
module apb_arb_rr2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            // On a tie, favour whoever was not served last.
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/apb_i2c_arbiter.sv
// rtl/apb_i2c_arbiter.sv - two-requester APB master with round-robin arbitration and access timeout
module apb_i2c_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];

    apb_arb_rr2 u_rr2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is only offered while idle and never during a reset cycle.
    assign accept     = (state == ST_IDLE && !PRESET) ? grant : 2'b00;
    assign req0_ready = accept[0];
    assign req1_ready = accept[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        PWRITE     <= grant[1] ? req1_write : req0_write;
                        PADDR      <= grant[1] ? req1_addr  : req0_addr;
                        PWDATA     <= grant[1] ? req1_wdata : req0_wdata;
                        PSELx      <= 1'b1;
                        PENABLE    <= 1'b0;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSELx          <= 1'b0;
                        PENABLE        <= 1'b0;
                        done_q[owner]  <= 1'b1;
                        rdata_q[owner] <= PWRITE ? '0 : PRDATA;
                        state          <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        PSELx          <= 1'b0;
                        PENABLE        <= 1'b0;
                        done_q[owner]  <= 1'b1;
                        err_q[owner]   <= 1'b1;
                        rdata_q[owner] <= '0;
                        state          <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_arbiter.sv
// tb/tb_apb_i2c_arbiter.sv - scoreboard bench for the two-requester APB arbiter
module tb_apb_i2c_arbiter;

    localparam int TO = 4;

    typedef struct {
        int         id;
        logic [7:0] addr;
        logic       err;
        logic [7:0] rdata;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       PRESET;
    logic [1:0] vld;
    logic [1:0] wr_s;
    logic [7:0] addr_s [2];
    logic [7:0] wd_s [2];
    logic       req0_ready, req0_done, req0_err;
    logic       req1_ready, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       PSELx, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic       PREADY;
    logic [7:0] PRDATA;

    exp_t       sb [$];
    exp_t       e;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         delay = 0;
    logic [7:0] rd_val = 8'h00;
    int         acc = 0;
    logic       moved = 1'b0;
    logic [7:0] setup_addr = 8'h00;

    always #5 clk = ~clk;

    apb_i2c_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK       (clk),
        .PRESET     (PRESET),
        .req0_valid (vld[0]),
        .req0_write (wr_s[0]),
        .req0_addr  (addr_s[0]),
        .req0_wdata (wd_s[0]),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req0_rdata (req0_rdata),
        .req1_valid (vld[1]),
        .req1_write (wr_s[1]),
        .req1_addr  (addr_s[1]),
        .req1_wdata (wd_s[1]),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .req1_rdata (req1_rdata),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input int id, input logic wr, input logic [7:0] a,
                            input int dly, input logic [7:0] rv);
        exp_t x;
        x.id    = id;
        x.addr  = a;
        x.err   = (dly >= TO);
        x.acc   = x.err ? TO : dly + 1;
        x.rdata = (wr || x.err) ? 8'h00 : rv;
        sb.push_back(x);
    endtask

    task automatic drive(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d);
        logic got = 1'b0;
        vld[id]    = 1'b1;
        wr_s[id]   = wr;
        addr_s[id] = a;
        wd_s[id]   = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_wait", 0, 1);
        @(posedge clk);
        #1;
        vld[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // APB slave: PREADY rises after `delay` wait cycles; PRDATA is junk unless ready.
    always @(negedge clk) begin
        if (PSELx && PENABLE) begin
            if (PADDR != setup_addr) moved = 1'b1;
            acc    = acc + 1;
            PREADY = (acc > delay);
            PRDATA = PREADY ? rd_val : 8'hEE;
        end else begin
            if (PSELx) begin
                acc        = 0;
                moved      = 1'b0;
                setup_addr = PADDR;
            end
            PREADY = 1'b1;
            PRDATA = 8'hEE;
        end
    end

    always @(negedge clk) begin
        if (!PRESET && (req0_done || req1_done)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_id", req1_done ? 1 : 0, e.id);
                check("done_single", {31'd0, req0_done & req1_done}, 0);
                check("err", req1_done ? req1_err : req0_err, e.err);
                check("rdata", req1_done ? req1_rdata : req0_rdata, e.rdata);
                check("access_cycles", acc, e.acc);
                check("paddr", PADDR, e.addr);
                check("paddr_stable", moved, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1;
        vld = 2'b00; wr_s = 2'b00;
        addr_s[0] = 0; addr_s[1] = 0; wd_s[0] = 0; wd_s[1] = 0;
        PREADY = 1'b1; PRDATA = 8'hEE;
        repeat (2) @(posedge clk);
        #1 vld = 2'b11;
        @(negedge clk);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_apb", {PSELx, PENABLE, PWRITE}, 0);
        check("rst_addr_data", {PADDR, PWDATA}, 0);
        check("rst_done_err", {req1_done, req0_done, req1_err, req0_err}, 0);
        check("rst_rdata", {req1_rdata, req0_rdata}, 0);
        vld = 2'b00;
        @(posedge clk);
        #1 PRESET = 1'b0;

        // Single write with zero wait states: exact cycle timing.
        delay = 0; rd_val = 8'h11;
        push_exp(0, 1'b1, 8'h04, 0, rd_val);
        drive(0, 1'b1, 8'h04, 8'hA5);
        check("w_setup", {PSELx, PENABLE, PWRITE}, 3'b101);
        check("w_pwdata", PWDATA, 8'hA5);
        @(posedge clk); #1;
        check("w_access", {PSELx, PENABLE}, 2'b11);
        @(posedge clk); #1;
        check("w_done_cycle3", {req0_done, req0_err, PSELx, PENABLE}, 4'b1000);
        drain();

        // Read with five wait states.
        delay = 5; rd_val = 8'h3C;
        push_exp(1, 1'b0, 8'h08, 5, rd_val);
        drive(1, 1'b0, 8'h08, 8'h00);
        drain();

        // Both requesters continuously valid: alternating grants from req0.
        delay = 0; rd_val = 8'h5A;
        push_exp(0, 1'b1, 8'h10, 0, rd_val);
        push_exp(1, 1'b0, 8'h11, 0, rd_val);
        push_exp(0, 1'b0, 8'h12, 0, rd_val);
        push_exp(1, 1'b1, 8'h13, 0, rd_val);
        fork
            begin drive(0, 1'b1, 8'h10, 8'h01); drive(0, 1'b0, 8'h12, 8'h02); end
            begin drive(1, 1'b0, 8'h11, 8'h03); drive(1, 1'b1, 8'h13, 8'h04); end
        join
        drain();

        // Slave never ready: timeout after TO access cycles, then a normal read.
        delay = 100; rd_val = 8'h77;
        push_exp(1, 1'b0, 8'h20, 100, rd_val);
        drive(1, 1'b0, 8'h20, 8'h00);
        drain();
        delay = 0; rd_val = 8'h99;
        push_exp(1, 1'b0, 8'h21, 0, rd_val);
        drive(1, 1'b0, 8'h21, 8'h00);
        drain();
        repeat (3) @(posedge clk);
        #1 check("rdata_hold", req1_rdata, 8'h99);

        // Reset during ACCESS aborts silently and restores the tie pointer.
        delay = 100;
        drive(0, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 20 && !PENABLE; i++) @(negedge clk);
        check("reached_access", PENABLE, 1);
        @(posedge clk); #1 PRESET = 1'b1;
        @(posedge clk); #1 PRESET = 1'b0;
        check("abort_apb", {PSELx, PENABLE, PWRITE}, 0);
        check("abort_addr", PADDR, 0);
        check("abort_done", {req1_done, req0_done}, 0);
        delay = 0; rd_val = 8'h42;
        push_exp(0, 1'b0, 8'h31, 0, rd_val);
        push_exp(1, 1'b1, 8'h32, 0, rd_val);
        fork
            drive(0, 1'b0, 8'h31, 8'h00);
            drive(1, 1'b1, 8'h32, 8'h55);
        join
        drain();

        // req1 arrives during req0's SETUP and is accepted alongside req0_done.
        delay = 0; rd_val = 8'h6B;
        push_exp(0, 1'b1, 8'h40, 0, rd_val);
        push_exp(1, 1'b0, 8'h41, 0, rd_val);
        fork
            drive(0, 1'b1, 8'h40, 8'hC3);
            begin
                for (int i = 0; i < 20 && !(PSELx && !PENABLE); i++) @(negedge clk);
                fork
                    drive(1, 1'b0, 8'h41, 8'h00);
                    begin
                        logic seen = 1'b0;
                        for (int i = 0; i < 20; i++) begin
                            @(negedge clk);
                            if (req1_ready) begin
                                check("ready_with_done", req0_done, 1);
                                seen = 1'b1;
                                break;
                            end
                        end
                        if (!seen) check("late_ready_seen", 0, 1);
                    end
                join
            end
        join
        drain();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
